itl_pb_sched: RTL
=================

// Module: itl_pb_sched
// PURPOSE
//   Two-requester scheduler for the HPGP turbo interleaver datapath (turbo_len + ram_dual).
//   Round-robin arbitrates PB jobs, streams the winner's dibits into the interleaver with pb_size held stable,
//   counts interleaved output beats to detect PB completion, then enforces an inter-PB gap.
//   Sits between the PB framers (src0 = data path, src1 = ROBO/mgmt path) and the interleaver top.
// PARAMETERS
//   LEN0     64    dibits per PB16  (pb_size 2'b00)
//   LEN1     544   dibits per PB136 (pb_size 2'b01)
//   LEN2     2080  dibits per PB520 (pb_size 2'b10); pb_size 2'b11 reserved
//   CNT_W    12    width of the beat counters (must hold LEN2)
//   GAP_CYC  2     idle cycles forced between PBs (>=1)
//   TMO_CYC  4096  max cycles in DRAIN without itl_dout_vld before timeout
// PORTS
//   clk           in   1  clock, all logic on rising edge
//   rst           in   1  synchronous reset, active-high
//   req           in   2  job request per source; held high until matching gnt bit rises
//   req_pb_size0  in   2  PB size of src0 job, sampled in GRANT
//   req_pb_size1  in   2  PB size of src1 job, sampled in GRANT
//   gnt           out  2  one-hot grant, held GRANT through end of DRAIN
//   s0_din/s1_din in   2  source dibit
//   s0_vld/s1_vld in   1  source dibit valid
//   s0_rdy/s1_rdy out  1  scheduler ready; beat transfers when vld & rdy
//   itl_din       out  2  dibit to interleaver (registered)
//   itl_din_vld   out  1  dibit valid to interleaver (registered)
//   itl_pb_size   out  2  PB size to interleaver, stable for whole job
//   itl_dout_vld  in   1  interleaver output-beat valid
//   done          out  2  1-cycle pulse on the granted source when job completes
//   err           out  1  1-cycle pulse: reserved pb_size or DRAIN timeout
//   busy          out  1  high in any state except IDLE
// BEHAVIOUR
//   Reset: state=IDLE, rr pointer=src0, gnt/rdy/itl_din/itl_din_vld/itl_pb_size/done/err/busy = 0, counters 0.
//   FSM: IDLE -> GRANT -> LOAD -> DRAIN -> GAP -> IDLE.
//   IDLE: if any req, pick per rr pointer (pointer source first if both); gnt set next cycle, go GRANT.
//   GRANT (1 cyc): latch pb_size into itl_pb_size, N = LENx. pb_size 2'b11 -> err pulse, gnt cleared,
//     no done, go GAP. Otherwise go LOAD. rr pointer moves to the other source on every grant.
//   LOAD: sX_rdy = 1 for granted source only while in_cnt < N (combinational from state/counter).
//     Each transfer: in_cnt++, itl_din/itl_din_vld registered next cycle; vld bubbles give itl_din_vld=0.
//     N-th transfer -> DRAIN next cycle; rdy low from that cycle on.
//   out_cnt counts itl_dout_vld in LOAD and DRAIN.
//   DRAIN: when out_cnt reaches N: done[granted] pulse, gnt cleared, go GAP.
//     Idle counter resets on each itl_dout_vld; reaching TMO_CYC -> err pulse, gnt cleared, no done, go GAP.
//   GAP: GAP_CYC cycles, then IDLE; req ignored until IDLE.
//   Ungranted source: rdy=0 always; its req is remembered only as a level (no queue).
//   req dropped while granted: ignored, job runs to completion.
//   Counters CNT_W bits, unsigned, no wrap in legal operation (in_cnt <= N <= LEN2).
//   itl_pb_size holds last value after job; changes only in GRANT.
//   rst mid-job: immediate return to reset values next edge; partial PB abandoned, no done/err.
//   Latency: req -> gnt 1 cycle; src beat -> itl_din_vld 1 cycle; last out beat -> done 1 cycle.
// TESTING
//   1. req=01, size 00, src0 streams 64 beats back-to-back, bench returns 64 dout_vld -> gnt=01, 64 itl_din_vld, done=01 once, itl_pb_size=00.
//   2. req=11 simultaneous from reset, both size 01 -> src0 served first (544 beats), then src1 after GAP_CYC+1 idle cycles; done 01 then 10.
//   3. src1 size 10 with vld toggling every other cycle -> exactly 2080 itl_din_vld, rdy drops after beat 2080, no extra beat accepted.
//   4. src0 req size 11 -> err pulse in GRANT+1, no rdy, no done, busy returns 0 after GAP.
//   5. size 00 job, bench withholds dout_vld after 10 beats -> err after TMO_CYC cycles, no done, next req serviced normally.
//   6. rst pulse at load beat 300 of PB136 -> all outputs 0 next cycle; fresh req completes correctly.

Source files
------------

// File: rtl/itl_pb_sched_if.sv
// Bundle of request/grant, source streaming and interleaver signals for the PB scheduler.
interface itl_pb_sched_if;
  logic [1:0] req;
  logic [1:0] req_pb_size0;
  logic [1:0] req_pb_size1;
  logic [1:0] gnt;
  logic [1:0] s0_din;
  logic [1:0] s1_din;
  logic       s0_vld;
  logic       s1_vld;
  logic       s0_rdy;
  logic       s1_rdy;
  logic [1:0] itl_din;
  logic       itl_din_vld;
  logic [1:0] itl_pb_size;
  logic       itl_dout_vld;
  logic [1:0] done;
  logic       err;
  logic       busy;

  // Environment side: PB framers plus the interleaver output strobe
  modport master (
    output req, req_pb_size0, req_pb_size1, s0_din, s1_din, s0_vld, s1_vld, itl_dout_vld,
    input  gnt, s0_rdy, s1_rdy, itl_din, itl_din_vld, itl_pb_size, done, err, busy
  );

  // Scheduler side
  modport slave (
    input  req, req_pb_size0, req_pb_size1, s0_din, s1_din, s0_vld, s1_vld, itl_dout_vld,
    output gnt, s0_rdy, s1_rdy, itl_din, itl_din_vld, itl_pb_size, done, err, busy
  );
endinterface

// File: rtl/itl_pb_sched.sv
// Two-source round-robin PB scheduler in front of the turbo interleaver.
// One job at a time: grant, stream the winner's dibits, wait for the interleaver
// to emit the same number of beats, then hold off for a fixed gap.
module itl_pb_sched #(
  parameter int LEN0    = 64,
  parameter int LEN1    = 544,
  parameter int LEN2    = 2080,
  parameter int CNT_W   = 12,
  parameter int GAP_CYC = 2,
  parameter int TMO_CYC = 4096
) (
  input  logic          clk,
  input  logic          rst,
  itl_pb_sched_if.slave bus
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {IDLE, GRANT, LOAD, DRAIN, GAP} state_t;

  state_t             state;
  state_t             next_state;
  logic               rr_ptr;
  logic               sel;
  logic [CNT_W-1:0]   in_cnt;
  logic [CNT_W-1:0]   out_cnt;
  logic [CNT_W-1:0]   len_n;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  logic               pick;
  logic [1:0]         size_g;
  logic [1:0]         din_g;
  logic               load_open;
  logic               xfer;
  logic [CNT_W-1:0]   out_next;
  logic               drain_done;
  logic               drain_tmo;

  function automatic logic [CNT_W-1:0] len_of(input logic [1:0] size);
    case (size)
      2'b00:   len_of = CNT_W'(LEN0);
      2'b01:   len_of = CNT_W'(LEN1);
      2'b10:   len_of = CNT_W'(LEN2);
      default: len_of = '0;
    endcase
  endfunction

  // Shared decode: arbitration winner, granted-source muxes and job-end conditions
  always_comb begin
    pick = 1'b0;
    if (bus.req == 2'b11) pick = rr_ptr;
    else if (bus.req[1])  pick = 1'b1;
    size_g     = sel ? bus.req_pb_size1 : bus.req_pb_size0;
    din_g      = sel ? bus.s1_din : bus.s0_din;
    load_open  = (state == LOAD) && (in_cnt < len_n);
    xfer       = load_open && (sel ? bus.s1_vld : bus.s0_vld);
    out_next   = out_cnt + {{(CNT_W-1){1'b0}}, bus.itl_dout_vld};
    drain_done = (state == DRAIN) && (out_next >= len_n);
    drain_tmo  = (state == DRAIN) && !bus.itl_dout_vld && (tmo_cnt == TMO_W'(TMO_CYC - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: IDLE -> GRANT -> LOAD -> DRAIN -> GAP -> IDLE, reserved size skips to GAP
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|bus.req) next_state = GRANT;
      GRANT:   next_state = (size_g == 2'b11) ? GAP : LOAD;
      LOAD:    if (xfer && (in_cnt == len_n - CNT_W'(1))) next_state = DRAIN;
      DRAIN:   if (drain_done || drain_tmo) next_state = GAP;
      GAP:     if (gap_cnt == GAP_W'(GAP_CYC - 1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Combinational outputs: ready only toward the granted source while beats remain
  always_comb begin
    bus.busy   = (state != IDLE);
    bus.s0_rdy = load_open && !sel;
    bus.s1_rdy = load_open && sel;
  end

  // Registered datapath: grant, job length, beat counters, interleaver feed and pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr          <= 1'b0;
      sel             <= 1'b0;
      bus.gnt         <= 2'b00;
      bus.itl_din     <= 2'b00;
      bus.itl_din_vld <= 1'b0;
      bus.itl_pb_size <= 2'b00;
      bus.done        <= 2'b00;
      bus.err         <= 1'b0;
      in_cnt          <= '0;
      out_cnt         <= '0;
      len_n           <= '0;
      tmo_cnt         <= '0;
      gap_cnt         <= '0;
    end else begin
      bus.done        <= 2'b00;
      bus.err         <= 1'b0;
      bus.itl_din_vld <= 1'b0;
      tmo_cnt         <= '0;
      gap_cnt         <= '0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            sel     <= pick;
            rr_ptr  <= ~pick;
            bus.gnt <= pick ? 2'b10 : 2'b01;
          end
        end
        GRANT: begin
          bus.itl_pb_size <= size_g;
          len_n           <= len_of(size_g);
          in_cnt          <= '0;
          out_cnt         <= '0;
          if (size_g == 2'b11) begin
            bus.err <= 1'b1;
            bus.gnt <= 2'b00;
          end
        end
        LOAD: begin
          out_cnt <= out_next;
          if (xfer) begin
            in_cnt          <= in_cnt + CNT_W'(1);
            bus.itl_din     <= din_g;
            bus.itl_din_vld <= 1'b1;
          end
        end
        DRAIN: begin
          out_cnt <= out_next;
          tmo_cnt <= bus.itl_dout_vld ? '0 : tmo_cnt + TMO_W'(1);
          if (drain_done) begin
            bus.done <= bus.gnt;
            bus.gnt  <= 2'b00;
          end else if (drain_tmo) begin
            bus.err <= 1'b1;
            bus.gnt <= 2'b00;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
